// File: rtl/branch_ctrl_if.sv
// Branch resolution bus between the ID stage and the branch controller.
interface branch_ctrl_if;
    logic        br_valid;
    logic [1:0]  br_type;
    logic        opnd_ready;
    logic        id_hold_ext;
    logic        cmp_eq;
    logic        cmp_ne;
    logic [31:0] rs_val;
    logic [31:0] target;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;

    // ID stage side: presents the branch, receives stall/redirect.
    modport master (
        output br_valid, br_type, opnd_ready, id_hold_ext, cmp_eq, cmp_ne, rs_val, target,
        input  br_stall, br_taken, br_target
    );

    // Controller side.
    modport slave (
        input  br_valid, br_type, opnd_ready, id_hold_ext, cmp_eq, cmp_ne, rs_val, target,
        output br_stall, br_taken, br_target
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch controller: resolves branches in ID with zero added latency once operands
// are forwarded, stalls while operands are pending, holds the decision while ID is
// frozen externally, and keeps branch/taken/stall statistics.
module branch_ctrl #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_ctrl_if.slave     bus,
    output logic             hazard_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int unsigned WAIT_LIM = MAX_WAIT + 1;
    localparam int unsigned WCNT_W   = $clog2(WAIT_LIM + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIM_W = WCNT_W'(WAIT_LIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wait_cnt;
    logic              held_cond;
    logic [31:0]       held_target;

    logic              cond;
    logic              resolve;
    logic              stall;
    logic [WCNT_W-1:0] wait_nxt;

    // Branch condition from comparator flags or the sign/zero of rs.
    always_comb begin
        cond = 1'b0;
        unique case (bus.br_type)
            2'b00: cond = bus.cmp_eq;
            2'b01: cond = bus.cmp_ne;
            2'b10: cond = bus.rs_val[31] | (bus.rs_val == 32'd0);
            2'b11: cond = ~bus.rs_val[31] & (bus.rs_val != 32'd0);
        endcase
    end

    // Output decode: stall while operands pending, redirect on resolve or while held.
    always_comb begin
        resolve       = 1'b0;
        stall         = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = 32'd0;
        case (state)
            IDLE, WAIT: begin
                if (bus.br_valid) begin
                    bus.br_target = bus.target;
                    if (bus.opnd_ready) begin
                        resolve      = 1'b1;
                        bus.br_taken = cond;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            HELD: begin
                bus.br_taken  = held_cond;
                bus.br_target = held_target;
            end
            default: ;
        endcase
        bus.br_stall = stall;
    end

    // Next wait count: first pending cycle loads 1, then saturating increment.
    always_comb begin
        wait_nxt = WCNT_W'(1);
        if (state == WAIT) begin
            wait_nxt = (wait_cnt == WAIT_LIM_W) ? wait_cnt : wait_cnt + WCNT_W'(1);
        end
    end

    // State, wait tracking, latched decision, sticky error and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            held_cond   <= 1'b0;
            held_target <= 32'd0;
            hazard_err  <= 1'b0;
            br_cnt      <= '0;
            taken_cnt   <= '0;
            stall_cnt   <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
                if (wait_nxt == WAIT_LIM_W) begin
                    hazard_err <= 1'b1;
                end
            end
            if (resolve) begin
                br_cnt <= br_cnt + CNT_W'(1);
                if (cond) begin
                    taken_cnt <= taken_cnt + CNT_W'(1);
                end
            end
            case (state)
                IDLE, WAIT: begin
                    if (stall) begin
                        state    <= WAIT;
                        wait_cnt <= wait_nxt;
                    end else begin
                        wait_cnt <= '0;
                        if (resolve && bus.id_hold_ext) begin
                            state       <= HELD;
                            held_cond   <= cond;
                            held_target <= bus.target;
                        end else begin
                            // Plain resolve, idle, or squash of a pending branch.
                            state <= IDLE;
                        end
                    end
                end
                HELD: begin
                    if (!bus.id_hold_ext) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a driver applies directed and random stimulus,
// a reference model predicts each cycle's response into a queue, and a monitor
// compares the DUT against it on the falling edge.
module tb_branch_ctrl;
    localparam int unsigned MAX_WAIT = 3;
    localparam int unsigned CNT_W    = 8;
    localparam int          CMASK    = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             hazard_err;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    branch_ctrl_if bus ();

    branch_ctrl #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hazard_err (hazard_err),
        .br_cnt     (br_cnt),
        .taken_cnt  (taken_cnt),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk_comb;
        bit          stall;
        bit          taken;
        logic [31:0] tgt;
        bit          haz;
        int          br;
        int          tk;
        int          st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: branch-level view of the controller.
    bit          m_held   = 0;
    bit          m_hcond  = 0;
    logic [31:0] m_htgt   = 0;
    int          m_waits  = 0;
    bit          m_haz    = 0;
    int          m_br     = 0;
    int          m_tk     = 0;
    int          m_st     = 0;

    function automatic bit branch_cond(input logic [1:0] typ, input bit eq, input bit ne,
                                       input logic [31:0] rs);
        case (typ)
            2'b00:   return eq;
            2'b01:   return ne;
            2'b10:   return $signed(rs) <= 0;
            default: return $signed(rs) > 0;
        endcase
    endfunction

    task automatic step(input bit rst, input bit valid, input logic [1:0] typ, input bit rdy,
                        input bit hold, input bit eq, input bit ne, input logic [31:0] rs,
                        input logic [31:0] tgt);
        exp_t e;
        bit   c;
        bit   res;
        reset           = rst;
        bus.br_valid    = valid;
        bus.br_type     = typ;
        bus.opnd_ready  = rdy;
        bus.id_hold_ext = hold;
        bus.cmp_eq      = eq;
        bus.cmp_ne      = ne;
        bus.rs_val      = rs;
        bus.target      = tgt;
        c   = branch_cond(typ, eq, ne, rs);
        res = !m_held && valid && rdy;
        e.chk_comb = !rst;
        e.stall    = !m_held && valid && !rdy;
        e.taken    = m_held ? m_hcond : (res && c);
        e.tgt      = m_held ? m_htgt : (valid ? tgt : 32'd0);
        e.haz      = m_haz;
        e.br       = m_br;
        e.tk       = m_tk;
        e.st       = m_st;
        q.push_back(e);
        if (rst) begin
            m_held = 0; m_hcond = 0; m_htgt = 0; m_waits = 0;
            m_haz = 0; m_br = 0; m_tk = 0; m_st = 0;
        end else if (m_held) begin
            if (!hold) m_held = 0;
        end else if (e.stall) begin
            m_st    = (m_st + 1) & CMASK;
            m_waits = m_waits + 1;
            if (m_waits >= MAX_WAIT + 1) m_haz = 1;
        end else if (res) begin
            m_br    = (m_br + 1) & CMASK;
            if (c) m_tk = (m_tk + 1) & CMASK;
            m_waits = 0;
            if (hold) begin
                m_held = 1; m_hcond = c; m_htgt = tgt;
            end
        end else begin
            m_waits = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each cycle's outputs against the oldest prediction.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk_comb) begin
                chk("br_stall", {31'd0, bus.br_stall}, {31'd0, e.stall});
                chk("br_taken", {31'd0, bus.br_taken}, {31'd0, e.taken});
                chk("br_target", bus.br_target, e.tgt);
            end
            chk("hazard_err", {31'd0, hazard_err}, {31'd0, e.haz});
            chk("br_cnt", 32'(br_cnt), 32'(e.br));
            chk("taken_cnt", 32'(taken_cnt), 32'(e.tk));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.st));
        end
    end

    initial begin
        reset           = 1'b1;
        bus.br_valid    = 1'b0;
        bus.br_type     = 2'b00;
        bus.opnd_ready  = 1'b0;
        bus.id_hold_ext = 1'b0;
        bus.cmp_eq      = 1'b0;
        bus.cmp_ne      = 1'b0;
        bus.rs_val      = 32'd0;
        bus.target      = 32'd0;
        @(posedge clk);
        #1;
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // Idle after reset.
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // bne taken, operands ready.
        step(0, 1, 2'b01, 1, 0, 0, 1, 0, 32'h0000_3010);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // beq waits 2 cycles then resolves not taken.
        step(0, 1, 2'b00, 0, 0, 0, 1, 0, 32'h0000_4000);
        step(0, 1, 2'b00, 0, 0, 0, 1, 0, 32'h0000_4000);
        step(0, 1, 2'b00, 1, 0, 0, 1, 0, 32'h0000_4000);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // bgtz on negative, then blez on zero.
        step(0, 1, 2'b11, 1, 0, 0, 0, 32'h8000_0000, 32'h0000_5000);
        step(0, 1, 2'b10, 1, 0, 0, 0, 32'h0000_0000, 32'h0000_6000);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // beq taken held for 3 cycles while inputs change.
        step(0, 1, 2'b00, 1, 1, 1, 0, 0, 32'h0000_7000);
        step(0, 1, 2'b00, 1, 1, 0, 1, 5, 32'h0000_7abc);
        step(0, 1, 2'b00, 0, 1, 1, 0, 7, 32'h0000_8888);
        step(0, 1, 2'b01, 1, 0, 0, 1, 9, 32'h0000_9999);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // Long operand wait: hazard sets and stays set after resolve.
        for (int i = 0; i < 5; i++) step(0, 1, 2'b01, 0, 0, 0, 1, 0, 32'h0000_a000);
        step(0, 1, 2'b01, 1, 0, 0, 1, 0, 32'h0000_a000);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2'b00, 1, 0, 1, 0, 0, 32'h0000_b000);
        // Squash a pending branch.
        step(0, 1, 2'b00, 0, 0, 0, 1, 0, 32'h0000_c000);
        step(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h0000_c000);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // Reset while waiting with stall_cnt built up.
        for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 0, 0, 0, 1, 0, 32'h0000_d000);
        step(1, 1, 2'b01, 0, 0, 0, 1, 0, 32'h0000_d000);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // Counter wrap: more taken branches than the counter can hold.
        for (int i = 0; i < 260; i++) step(0, 1, 2'b01, 1, 0, 0, 1, 0, 32'(i));
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // Reset while held.
        step(0, 1, 2'b00, 1, 1, 1, 0, 0, 32'h0000_e000);
        step(1, 1, 2'b00, 1, 1, 1, 0, 0, 32'h0000_e000);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bit eq;
            eq = 1'($urandom_range(0, 1));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, eq, ~eq,
                 ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom);
        end
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 3: operand-wait cycles beyond which hazard_err is set.
REQ-002 Parameter CNT_W, default 32: width of each statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 br_valid  input  1  ID stage holds a branch instruction.
REQ-006 br_type  input  2  00 beq, 01 bne, 10 blez, 11 bgtz.
REQ-007 opnd_ready  input  1  forwarded rs/rt values valid this cycle.
REQ-008 id_hold_ext  input  1  ID frozen by an external stall source (e.g. multiply/divide busy).
REQ-009 cmp_eq  input  1  rs==rt, from the equality comparator.
REQ-010 cmp_ne  input  1  rs!=rt, from the inequality comparator.
REQ-011 rs_val  input  32  forwarded rs value.
REQ-012 target  input  32  branch target address computed in ID.
REQ-013 br_stall  output  1  freeze PC and IF/ID, insert bubble into EX.
REQ-014 br_taken  output  1  select target for next PC this cycle.
REQ-015 br_target  output  32  address paired with br_taken.
REQ-016 hazard_err  output  1  sticky: operand wait exceeded MAX_WAIT.
REQ-017 br_cnt, taken_cnt, stall_cnt  output  CNT_W each  resolved branches, taken branches, stall cycles.

Function
REQ-018 States: IDLE, WAIT, HELD; two-bit state register.
REQ-019 Condition cond = cmp_eq (00), cmp_ne (01), rs_val[31] | (rs_val==0) (10), ~rs_val[31] & (rs_val!=0) (11); signed 32-bit, no other arithmetic.
REQ-020 IDLE, br_valid & ~opnd_ready: br_stall=1 combinationally, br_taken=0, next WAIT, wait counter loaded with 1.
REQ-021 IDLE or WAIT, br_valid & opnd_ready: resolve this cycle, br_stall=0, br_taken=cond, br_target=target, zero added latency.
REQ-022 Resolve with id_hold_ext=0: next IDLE; with id_hold_ext=1: latch cond and target, next HELD.
REQ-023 WAIT, br_valid & ~opnd_ready: br_stall=1, wait counter increments, saturating at MAX_WAIT+1.
REQ-024 Wait counter reaching MAX_WAIT+1: hazard_err set, cleared only by reset; stall continues.
REQ-025 WAIT, br_valid=0 (squash): next IDLE, no resolve, no counter update except stall_cnt already counted.
REQ-026 HELD: br_taken and br_target driven from latched values, no re-resolve, cmp_*/rs_val/opnd_ready ignored; id_hold_ext=0 -> IDLE.
REQ-027 br_taken asserted only on the resolving cycle and during HELD; 0 otherwise.
REQ-028 br_target = target when not HELD and latched target in HELD.
REQ-029 br_cnt +1 per resolve; taken_cnt +1 per resolve with cond=1; stall_cnt +1 per cycle br_stall=1; HELD cycles increment nothing.
REQ-030 Counters wrap modulo 2^CNT_W without flag.
REQ-031 br_valid=0 in IDLE: all combinational outputs 0, state unchanged.
REQ-032 Delay slot retained: controller never flushes IF/ID.

Reset
REQ-033 reset=1 at clock edge: state IDLE, wait counter 0, latched cond/target 0, hazard_err 0, all counters 0.
REQ-034 Reset in WAIT or HELD abandons the branch; outputs follow IDLE rules next cycle; reset dominates all inputs.

Verification
REQ-035 bne, cmp_ne=1, opnd_ready=1, target=0x00003010 -> same cycle br_taken=1, br_target=0x00003010, br_stall=0; br_cnt=1, taken_cnt=1.
REQ-036 beq, opnd_ready low 2 cycles then high, cmp_eq=0 -> br_stall=1 for 2 cycles, stall_cnt=2, resolve br_taken=0, br_cnt=1, hazard_err=0.
REQ-037 MAX_WAIT=3, opnd_ready low 5 cycles -> hazard_err=1 from fourth wait cycle, stays 1 after resolve until reset.
REQ-038 bgtz rs_val=0x80000000 then blez rs_val=0 -> first br_taken=0, second br_taken=1; taken_cnt=1.
REQ-039 beq taken with id_hold_ext=1 for 3 cycles, cmp_eq toggled and target changed meanwhile -> br_taken=1 with original target all 4 cycles, br_cnt=1.
REQ-040 reset asserted in WAIT with stall_cnt=5 -> next cycle IDLE, br_stall=0 if br_valid=0, all counters 0; taken_cnt preloaded 0xFFFFFFFF plus one taken -> wraps to 0.
